// File: rtl/scfifo_pkg.sv
// Shared definitions for the single-clock FIFO write-side arbiter.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
package scfifo_pkg;

    // Arbiter FSM encoding
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Default FIFO beat width
    localparam int DEF_DATA_W = 8;

    // Bits needed to index 'value' items; never less than 1 so a port is always at least 1 bit
    function automatic int log2_ceil(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/scfifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching upward from last_winner+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module rr_pick
    import scfifo_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_winner,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    // Scan from farthest to nearest candidate so the nearest hit after last_winner overwrites the rest
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (int'(last_winner) + k) % N;
            if (req[idx]) begin
                winner  = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scfifo_wr_arbiter.sv
// Round-robin packet arbiter for a FIFO push port; optional lock watchdog under SCFIFO_ARB_TIMEOUT_EN.
// Latency: one arbitration cycle before the first beat, one dead cycle after each packet's last beat.
// Backpressure: fifo_full drops the owner's req_ready; the lock is kept until the last beat is accepted.
module scfifo_wr_arbiter
    import scfifo_pkg::*;
#(
    parameter int NB_REQ  = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NB_REQ-1:0]            req_valid,
    input  logic [NB_REQ-1:0]            req_last,
    input  logic [NB_REQ*DATA_W-1:0]     req_data,
    output logic [NB_REQ-1:0]            req_ready,
    output logic                         fifo_push,
    output logic [DATA_W-1:0]            fifo_data,
    input  logic                         fifo_full,
    output logic [log2_ceil(NB_REQ)-1:0] grant_id,
    output logic                         locked,
    output logic                         arb_timeout
);

    localparam int GW = log2_ceil(NB_REQ);

    if (NB_REQ < 2 || NB_REQ > 8 || TIMEOUT < 1) begin : g_param_err
        $error("scfifo_wr_arbiter: NB_REQ must be 2..8 and TIMEOUT at least 1");
    end

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_winner_q, last_winner_d;
    logic          arb_timeout_q, arb_timeout_d;

    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic          g_valid;
    logic          g_last;
    logic          beat_acc;
    logic          wdog_fire;

    rr_pick #(
        .N  (NB_REQ),
        .IW (GW)
    ) u_rr_pick (
        .req         (req_valid),
        .last_winner (last_winner_q),
        .winner      (pick_idx),
        .any_req     (pick_any)
    );

    // Owner's handshake view, taken from the registered grant
    always_comb begin
        g_valid  = req_valid[grant_q];
        g_last   = req_last[grant_q];
        beat_acc = (state_q == ST_LOCKED) && g_valid && !fifo_full;
    end

    // Route the owner's beat to the FIFO; everything quiet while idle
    always_comb begin
        req_ready = '0;
        fifo_push = 1'b0;
        fifo_data = '0;
        if (state_q == ST_LOCKED) begin
            fifo_push = beat_acc;
            for (int i = 0; i < NB_REQ; i++) begin
                if (grant_q == GW'(i)) begin
                    req_ready[i] = !fifo_full;
                    fifo_data    = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef SCFIFO_ARB_TIMEOUT_EN
    localparam int TW = log2_ceil(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    // Count locked cycles with the owner silent; a stalled-but-valid owner does not count
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        wdog_fire  = 1'b0;
        if (state_q != ST_LOCKED || beat_acc) begin
            idle_cnt_d = '0;
        end else if (!g_valid) begin
            if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
                wdog_fire  = 1'b1;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    // Next-state: grab a winner when idle, release on the owner's last beat or a watchdog expiry
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_winner_d = last_winner_q;
        arb_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_LOCKED;
                    grant_d = pick_idx;
                end
            end
            ST_LOCKED: begin
                if ((beat_acc && g_last) || wdog_fire) begin
                    state_d       = ST_IDLE;
                    last_winner_d = grant_q;
                    arb_timeout_d = wdog_fire;
                end
            end
        endcase
    end

    // FSM and registered outputs; requester 0 has first priority after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_winner_q <= GW'(NB_REQ - 1);
            arb_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_winner_q <= last_winner_d;
            arb_timeout_q <= arb_timeout_d;
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign grant_id    = grant_q;
    assign arb_timeout = arb_timeout_q;

endmodule

// File: tb/tb_scfifo_wr_arbiter.sv
// Bench for scfifo_wr_arbiter: directed scenarios plus randomized producers against a reference model.
// Latency: model predicts every output each cycle; pushes are also checked end-to-end per requester.
// Backpressure: fifo_full is driven randomly; producers hold beats until accepted.
module tb_scfifo_wr_arbiter;

    localparam int NB  = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;
    localparam int GW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NB-1:0]     req_valid;
    logic [NB-1:0]     req_last;
    logic [NB*DW-1:0]  req_data;
    logic [NB-1:0]     req_ready;
    logic              fifo_push;
    logic [DW-1:0]     fifo_data;
    logic              fifo_full;
    logic [GW-1:0]     grant_id;
    logic              locked;
    logic              arb_timeout;

    always #5 clk = ~clk;

    scfifo_wr_arbiter #(
        .NB_REQ  (NB),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_push   (fifo_push),
        .fifo_data   (fifo_data),
        .fifo_full   (fifo_full),
        .grant_id    (grant_id),
        .locked      (locked),
        .arb_timeout (arb_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Producer beat queues: {last, data}
    logic [8:0] bmem [NB][256];
    int hd  [NB];
    int tl  [NB];
    int gap [NB];
    bit rand_gaps = 1'b0;

    // Reference model: owner (-1 = idle), round-robin pointer, silent-cycle counter
    int m_owner = -1;
    int m_rr    = NB - 1;
    int m_cnt   = 0;
    bit m_tmo   = 1'b0;
    bit m_grant_chk = 1'b1;

    // Observation logs
    bit   acc_obs [NB];
    int   push_id_q [$];
    int   push_dat_q [$];
    bit   stream_on = 1'b0;
    int   exp_seq [NB];
    int   seq_gen [NB];
    int   open_id = -1;
    int   n_gen = 0;
    int   n_stream_push = 0;

    task automatic push_beat(input int r, input logic [7:0] d, input bit l);
        bmem[r][tl[r] % 256] = {l, d};
        tl[r]++;
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int r = 0; r < NB; r++) begin
            e = (tl[r] != hd[r]) ? bmem[r][hd[r] % 256] : 9'h0;
            req_valid[r]         = (tl[r] != hd[r]) && (gap[r] == 0);
            req_last[r]          = req_valid[r] & e[8];
            req_data[r*DW +: DW] = e[7:0];
        end
    endtask

    task automatic flush_producers();
        for (int r = 0; r < NB; r++) begin
            hd[r]  = tl[r];
            gap[r] = 0;
        end
        drive();
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int r = 0; r < NB; r++) begin
            if (hd[r] != tl[r]) e = 1'b0;
        end
        return e;
    endfunction

    // One clock: compare at negedge, advance model, then update producers after the edge
    task automatic step();
        logic [DW-1:0] exp_dat;
        int            exp_rdy;
        bit            acc;
        bit            found;
        int            c;
        int            id;
        @(negedge clk);
        if (rst) begin
            m_owner = -1; m_rr = NB - 1; m_cnt = 0; m_tmo = 1'b0; m_grant_chk = 1'b1;
        end
        exp_dat = (m_owner >= 0) ? req_data[m_owner*DW +: DW] : '0;
        exp_rdy = (m_owner >= 0 && !fifo_full) ? (1 << m_owner) : 0;
        check_eq("locked", locked, m_owner >= 0);
        if (m_owner >= 0)      check_eq("grant_id", grant_id, m_owner);
        else if (m_grant_chk)  check_eq("grant_id_rst", grant_id, 0);
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("fifo_push", fifo_push, (m_owner >= 0) && req_valid[m_owner] && !fifo_full);
        check_eq("fifo_data", fifo_data, exp_dat);
        check_eq("arb_timeout", arb_timeout, m_tmo);
        for (int r = 0; r < NB; r++) acc_obs[r] = req_valid[r] && req_ready[r];
        if (fifo_push) begin
            push_id_q.push_back(m_owner);
            push_dat_q.push_back(int'(fifo_data));
            if (stream_on) begin
                id = int'(fifo_data[7:6]);
                n_stream_push++;
                check_eq("stream_seq", fifo_data[5:0], exp_seq[id] % 64);
                exp_seq[id]++;
                if (open_id >= 0) check_eq("interleave", id, open_id);
                open_id = req_last[id] ? -1 : id;
            end
        end
        m_tmo = 1'b0;
        if (!rst) begin
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NB; k++) begin
                    c = (m_rr + k) % NB;
                    if (!found && req_valid[c]) begin
                        found = 1'b1; m_owner = c; m_cnt = 0; m_grant_chk = 1'b0;
                    end
                end
            end else begin
                acc = req_valid[m_owner] && !fifo_full;
                if (acc && req_last[m_owner]) begin
                    m_rr = m_owner; m_owner = -1; m_cnt = 0;
                end else if (acc) begin
                    m_cnt = 0;
                end
`ifdef SCFIFO_ARB_TIMEOUT_EN
                else if (!req_valid[m_owner]) begin
                    m_cnt++;
                    if (m_cnt == TMO) begin
                        m_rr = m_owner; m_owner = -1; m_cnt = 0; m_tmo = 1'b1;
                        open_id = -1;
                    end
                end
`endif
            end
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NB; r++) begin
            if (acc_obs[r]) begin
                hd[r]++;
                if (rand_gaps && $urandom_range(0, 7) == 0) gap[r] = $urandom_range(1, 3);
            end else if (gap[r] > 0) begin
                gap[r]--;
            end
        end
        drive();
    endtask

    task automatic clear_logs();
        push_id_q.delete();
        push_dat_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ids_t2 [4];
        int ids_t4 [7];
        int dat_t4 [7];
        bit seen;
        fifo_full = 1'b0;
        for (int r = 0; r < NB; r++) begin
            hd[r] = 0; tl[r] = 0; gap[r] = 0; exp_seq[r] = 0; seq_gen[r] = 0;
        end
        drive();

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        step();

        // T1: requester 0, three beats
        push_beat(0, 8'h11, 1'b0); push_beat(0, 8'h22, 1'b0); push_beat(0, 8'h33, 1'b1);
        drive(); clear_logs();
        step();
        check_eq("t1_locked", locked, 1);
        check_eq("t1_grant", grant_id, 0);
        repeat (3) step();
        check_eq("t1_npush", push_dat_q.size(), 3);
        if (push_dat_q.size() == 3) begin
            check_eq("t1_d0", push_dat_q[0], 32'h11);
            check_eq("t1_d1", push_dat_q[1], 32'h22);
            check_eq("t1_d2", push_dat_q[2], 32'h33);
        end
        check_eq("t1_unlock", locked, 0);

        // T2: requester 1 once so last_winner=1, then 1 and 3 contend with single-beat packets
        push_beat(1, 8'h41, 1'b1); drive();
        step(); step();
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            push_beat(1, 8'(8'h50 + k), 1'b1);
            push_beat(3, 8'(8'h70 + k), 1'b1);
        end
        drive();
        repeat (8) step();
        ids_t2 = '{3, 1, 3, 1};
        check_eq("t2_npush", push_id_q.size(), 4);
        if (push_id_q.size() == 4)
            for (int k = 0; k < 4; k++) check_eq("t2_order", push_id_q[k], ids_t2[k]);

        // T3: requester 2, four beats, FIFO full for 5 cycles after the first beat
        for (int k = 0; k < 4; k++) push_beat(2, 8'(8'hA1 + k), k == 3);
        drive(); clear_logs();
        step(); step();
        fifo_full = 1'b1;
        repeat (5) begin
            #1;
            check_eq("t3_ready_stall", req_ready[2], 0);
            check_eq("t3_push_stall", fifo_push, 0);
            check_eq("t3_grant_held", grant_id, 2);
            step();
        end
        fifo_full = 1'b0;
        for (int i = 0; i < 10 && push_dat_q.size() < 4; i++) step();
        check_eq("t3_npush", push_dat_q.size(), 4);
        if (push_dat_q.size() == 4)
            for (int k = 0; k < 4; k++) check_eq("t3_data", push_dat_q[k], 32'hA1 + k);
        step();

        // T4: all requesters valid at reset release
        rst = 1'b1;
        step();
        push_beat(0, 8'h01, 1'b0); push_beat(0, 8'h02, 1'b1); push_beat(0, 8'h05, 1'b1);
        push_beat(1, 8'h11, 1'b1);
        push_beat(2, 8'h21, 1'b0); push_beat(2, 8'h22, 1'b1);
        push_beat(3, 8'h31, 1'b1);
        drive();
        step();
        rst = 1'b0;
        clear_logs();
        for (int i = 0; i < 40 && push_dat_q.size() < 7; i++) step();
        ids_t4 = '{0, 0, 1, 2, 2, 3, 0};
        dat_t4 = '{32'h01, 32'h02, 32'h11, 32'h21, 32'h22, 32'h31, 32'h05};
        check_eq("t4_npush", push_dat_q.size(), 7);
        if (push_dat_q.size() == 7)
            for (int k = 0; k < 7; k++) begin
                check_eq("t4_id", push_id_q[k], ids_t4[k]);
                check_eq("t4_data", push_dat_q[k], dat_t4[k]);
            end
        step();

        // T5: reset during beat 2 of a 4-beat packet from requester 1
        for (int k = 0; k < 4; k++) push_beat(1, 8'(8'h61 + k), k == 3);
        drive();
        step(); step();
        rst = 1'b1;
        #1;
        check_eq("t5_async_locked", locked, 0);
        check_eq("t5_async_push", fifo_push, 0);
        check_eq("t5_async_ready", req_ready, 0);
        step();
        flush_producers();
        rst = 1'b0;
        step();
        push_beat(1, 8'h71, 1'b1); push_beat(0, 8'h72, 1'b1); drive();
        step();
        check_eq("t5_first_winner", grant_id, 0);
        repeat (6) step();

        // T6: requester 2 sends one non-last beat then goes silent
        push_beat(2, 8'h81, 1'b0); drive();
        step(); step();
`ifdef SCFIFO_ARB_TIMEOUT_EN
        seen = 1'b0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            step();
            if (arb_timeout) begin
                seen = 1'b1;
                check_eq("t6_tmo_delay", k, TMO);
                check_eq("t6_tmo_unlock", locked, 0);
            end
        end
        check_eq("t6_tmo_seen", seen, 1);
        push_beat(0, 8'h90, 1'b1); push_beat(3, 8'h93, 1'b1); drive();
        step();
        check_eq("t6_next_winner", grant_id, 3);
        repeat (6) step();
`else
        seen = 1'b0;
        repeat (40) begin
            step();
            if (arb_timeout) seen = 1'b1;
        end
        check_eq("t6_hold_locked", locked, 1);
        check_eq("t6_hold_grant", grant_id, 2);
        check_eq("t6_no_timeout", seen, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        // Randomized producers and backpressure, checked against the model and per-requester streams
        flush_producers();
        stream_on = 1'b1;
        rand_gaps = 1'b1;
        open_id   = -1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int r = 0; r < NB; r++) begin
                if (hd[r] == tl[r] && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        push_beat(r, 8'((r << 6) | (seq_gen[r] % 64)), b == len - 1);
                        seq_gen[r]++;
                        n_gen++;
                    end
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            drive();
            step();
        end
        fifo_full = 1'b0;
        drive();
        for (int i = 0; i < 400 && !all_empty(); i++) step();
        check_eq("drain_empty", all_empty(), 1);
        check_eq("push_count", n_stream_push, n_gen);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scfifo_wr_arbiter.md
Name: scfifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares the push port of one single-clock FIFO (8-bit, depth 4 by default) between NB_REQ producers. Each producer sends packets of 1..n beats on a valid/ready/last handshake. Once a producer is granted, it keeps the FIFO until its last beat is accepted, so packets are never interleaved. The block sits directly in front of the FIFO's push/full/data_in ports.

Parameters:
- NB_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, beat width; must match the FIFO data width.
- TIMEOUT, 16, idle-cycle limit for the lock watchdog; used only when SCFIFO_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NB_REQ  per-requester beat valid.
- req_last  in  NB_REQ  per-requester last beat of packet.
- req_data  in  NB_REQ*DATA_W  packed beats; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NB_REQ  per-requester beat accepted.
- fifo_push  out  1  FIFO push strobe.
- fifo_data  out  DATA_W  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- grant_id  out  clog2(NB_REQ)  current owner; meaningful only while locked.
- locked  out  1  high while a packet owns the FIFO.
- arb_timeout  out  1  one-cycle pulse when the watchdog releases a lock; constant 0 without the macro.

Behaviour:
- Reset values:
  - FSM = IDLE, locked = 0, grant_id = 0.
  - Round-robin pointer last_winner = NB_REQ-1, so requester 0 has first priority after reset.
  - req_ready = 0, fifo_push = 0, arb_timeout = 0.
- FSM states:
  - IDLE -> LOCKED: on any req_valid. Winner is the first set bit searching upward from last_winner+1 (mod NB_REQ). grant_id and locked are registered.
  - Arbitration latency is 1 cycle. No beat transfers in the cycle the decision is made.
  - LOCKED -> IDLE: on the cycle the granted requester's beat with req_last=1 is accepted. last_winner <= grant_id on that edge.
  - The next arbitration starts in the following cycle, so there is one dead cycle between packets.
- Datapath in LOCKED (combinational from registered grant_id):
  - req_ready[g] = !fifo_full; all other ready bits = 0.
  - fifo_push = req_valid[g] & !fifo_full.
  - fifo_data = req_data slice g. It is driven with slice g whenever locked, and 0 in IDLE.
  - A beat is accepted when req_valid[g] & req_ready[g]. fifo_push is never asserted while fifo_full = 1.
- Boundary conditions:
  - fifo_full high mid-packet: the lock is held and the requester stalls. Data and last must stay stable while valid is high (producer rule). The checker flags violations.
  - Single-beat packet (valid & last in the first locked cycle, FIFO not full): accepted, back to IDLE next edge.
  - Granted requester drops valid mid-packet: the lock is held indefinitely (without the macro).
  - Only one requester active: it wins every arbitration, with the one dead cycle between its packets.
  - Requests arriving while locked are ignored until IDLE. No request is lost, because valid must be held.
  - rst asserted mid-packet: immediate return to reset values. A partial packet may remain in the FIFO; flushing is the system's responsibility.
  - last_winner wraps from NB_REQ-1 to 0.

Optional Feature:
- Macro SCFIFO_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) increments on each LOCKED cycle where req_valid[g] = 0.
  - It clears on any accepted beat and on entry to LOCKED.
  - It does not count while valid = 1 and fifo_full = 1.
  - When it reaches TIMEOUT: FSM -> IDLE, last_winner <= grant_id, arb_timeout pulses 1 cycle.
- Undefined: no counter; arb_timeout tied to 0; the lock is released only by last.

Decomposition:
- Package scfifo_pkg holds:
  - FSM state encoding (IDLE=1'b0, LOCKED=1'b1).
  - Default DATA_W = 8.
  - Log2 helper function for NB_REQ and TIMEOUT widths.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last_winner. Outputs: winner index, any_req.
  - Reusable for a future read-side arbiter.
- FSM, datapath mux and watchdog stay in scfifo_wr_arbiter.

Test Plan:
- Reset, then requester 0 sends a 3-beat packet 0x11, 0x22, 0x33 with fifo_full=0:
  - grant_id=0 one cycle after valid.
  - fifo_push high 3 consecutive cycles with data 0x11, 0x22, 0x33.
  - locked falls after the beat with last.
- Requesters 1 and 3 both hold 1-beat packets continuously, last_winner=1:
  - grants alternate 3, 1, 3, 1 with a dead cycle between each.
  - Exactly 4 pushes in 8 cycles.
- Requester 2 packet of 4 beats, fifo_full asserted on beat 2 for 5 cycles:
  - req_ready[2]=0 and fifo_push=0 for those 5 cycles; grant held.
  - All 4 beats pushed in order.
- All 4 requesters valid at reset release:
  - grant order 0, 1, 2, 3, 0.
  - No beat from another requester appears between a packet's first beat and its last beat.
- rst pulsed during beat 2 of a 4-beat packet from requester 1:
  - locked=0, fifo_push=0 and req_ready=0 asynchronously.
  - After release, requester 0 wins first when valid.
- With SCFIFO_ARB_TIMEOUT_EN, TIMEOUT=16: requester 2 sends 1 beat without last, then drops valid:
  - arb_timeout pulses exactly 16 cycles after the last accepted beat; locked=0 the same cycle.
  - Next arbitration favours requester 3.
